adc_frame_reader: RTL and testbench

ADC_FRAME_READER -- requirements
Module: adc_frame_reader

---
 rtl/adc_frame_reader_if.sv | 22 ++
 rtl/adc_frame_reader.sv | 143 ++++++++++++++
 tb/tb_adc_frame_reader.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_frame_reader_if.sv
// Serial ADC pin bundle: conversion start, chip select, serial clock and data.
// master = reader side (drives convst/cs_n/sclk), slave = ADC side (drives sdo).
interface adc_frame_reader_if;
    logic convst;
    logic cs_n;
    logic sclk;
    logic sdo;

    modport master (
        output convst,
        output cs_n,
        output sclk,
        input  sdo
    );

    modport slave (
        input  convst,
        input  cs_n,
        input  sclk,
        output sdo
    );
endinterface

// File: rtl/adc_frame_reader.sv
// Single-shot serial ADC reader: convst pulse, then 16-bit MSB-first readout.
// Ports: clk_in, rst_n (async, active-low), start, adc (convst/cs_n/sclk/sdo),
//        data (last sample), data_valid (1-cycle pulse), busy (not IDLE).
module adc_frame_reader #(
    parameter int SCLK_DIV    = 4,
    parameter int CONV_CYCLES = 100
) (
    input  logic                      clk_in,
    input  logic                      rst_n,
    input  logic                      start,
    adc_frame_reader_if.master        adc,
    output logic               [15:0] data,
    output logic                      data_valid,
    output logic                      busy
);

    localparam int          HALF      = SCLK_DIV / 2;
    localparam logic [15:0] CONV_LAST = 16'(CONV_CYCLES - 1);
    localparam logic [15:0] HALF_LAST = 16'(HALF - 1);
    localparam logic [15:0] HALF_W    = 16'(HALF);
    localparam logic [15:0] PER_LAST  = 16'(SCLK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV,
        S_SETUP,
        S_SHIFT,
        S_DONE
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [4:0]  bit_q, bit_d;
    logic [15:0] shift_q, shift_d;
    logic [15:0] data_q, data_d;
    logic        dv_q, dv_d;
    logic        busy_q, busy_d;
    logic        convst_q, convst_d;
    logic        cs_n_q, cs_n_d;
    logic        sclk_q, sclk_d;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            data_q   <= '0;
            dv_q     <= 1'b0;
            busy_q   <= 1'b0;
            convst_q <= 1'b0;
            cs_n_q   <= 1'b1;
            sclk_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            data_q   <= data_d;
            dv_q     <= dv_d;
            busy_q   <= busy_d;
            convst_q <= convst_d;
            cs_n_q   <= cs_n_d;
            sclk_q   <= sclk_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        dv_d    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_CONV;
                    cnt_d   = '0;
                    bit_d   = '0;
                end
            end
            S_CONV: begin
                if (cnt_q == CONV_LAST) begin
                    state_d = S_SETUP;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_SETUP: begin
                if (cnt_q == HALF_LAST) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_SHIFT: begin
                // cnt_q is the phase within one SCLK period
                if (cnt_q == PER_LAST) begin
                    cnt_d = '0;
                    if (bit_q == 5'd15) begin
                        state_d = S_DONE;
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                data_d  = shift_q;
                dv_d    = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so pins change
        // on the same edge as the state they belong to.
        sclk_d   = (state_d == S_SHIFT) && (cnt_d >= HALF_W);
        convst_d = (state_d == S_CONV);
        cs_n_d   = !((state_d == S_SETUP) || (state_d == S_SHIFT));
        busy_d   = (state_d != S_IDLE);

        // Capture on the edge that raises sclk, before the ADC moves sdo.
        if (sclk_d && !sclk_q) begin
            shift_d = {shift_q[14:0], adc.sdo};
        end
    end

    assign adc.convst = convst_q;
    assign adc.cs_n   = cs_n_q;
    assign adc.sclk   = sclk_q;
    assign data       = data_q;
    assign data_valid = dv_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_adc_frame_reader.sv
// Randomized bench for adc_frame_reader with a timing-table reference model.
// Ports: none (top-level bench).
module tb_adc_frame_reader;

    localparam int SD = 4;
    localparam int CC = 8;
    localparam int H  = SD / 2;
    localparam int SL = 16 * SD;
    localparam int L  = CC + H + SL + 1;

    logic        clk_in = 1'b0;
    logic        rst_n  = 1'b0;
    logic        start  = 1'b0;
    logic [15:0] data;
    logic        data_valid;
    logic        busy;

    adc_frame_reader_if bus ();

    adc_frame_reader #(
        .SCLK_DIV    (SD),
        .CONV_CYCLES (CC)
    ) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .start      (start),
        .adc        (bus),
        .data       (data),
        .data_valid (data_valid),
        .busy       (busy)
    );

    always #5 clk_in = ~clk_in;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // ADC: latches a word when selected, presents MSB first,
    // advances one bit after every sclk rise.
    logic [15:0] next_word = 16'h0;
    logic [15:0] adc_word  = 16'h0;
    int          idx       = 16;

    initial forever begin
        @(negedge bus.cs_n or posedge bus.sclk);
        if (bus.sclk) begin
            idx++;
        end else begin
            adc_word = next_word;
            idx      = 0;
        end
    end

    assign bus.sdo = (idx < 16) ? adc_word[4'(15 - idx)] : 1'b0;

    // Reference model: a frame is a timeline indexed by k = edges since
    // the sampling edge; every output is a fixed function of k.
    int          cyc = 0;
    int          t0  = 0;
    bit          act = 1'b0;
    logic [15:0] frame_word = 16'h0;
    logic [15:0] exp_data   = 16'h0;
    logic        e_convst = 1'b0;
    logic        e_cs_n   = 1'b1;
    logic        e_sclk   = 1'b0;
    logic        e_dv     = 1'b0;
    logic        e_busy   = 1'b0;

    initial forever begin
        int k;
        int s;
        @(posedge clk_in or negedge rst_n);
        if (!rst_n) begin
            act      = 1'b0;
            exp_data = 16'h0;
        end else begin
            cyc++;
            if ((!act || (cyc - t0 > L)) && start) begin
                act = 1'b1;
                t0  = cyc;
            end
            if (act && (cyc - t0 == CC)) frame_word = next_word;
            if (act && (cyc - t0 == L))  exp_data   = frame_word;
        end
        k        = act ? (cyc - t0) : 1000000;
        s        = k - CC - H;
        e_convst = (k < CC);
        e_cs_n   = !((k >= CC) && (k < CC + H + SL));
        e_sclk   = (s >= 0) && (s < SL) && ((s % SD) >= H);
        e_busy   = (k < L);
        e_dv     = (k == L);
    end

    // Per-cycle compare plus pin-level protocol checks.
    int   dv_cnt    = 0;
    int   conv_hi   = 0;
    int   rise_cnt  = 0;
    int   hi_run    = 0;
    bit   seen_fr   = 1'b0;
    logic prev_sclk = 1'b0;
    logic prev_cs_n = 1'b1;

    initial forever begin
        @(negedge clk_in);
        chk("convst", 16'(bus.convst), 16'(e_convst));
        chk("cs_n", 16'(bus.cs_n), 16'(e_cs_n));
        chk("sclk", 16'(bus.sclk), 16'(e_sclk));
        chk("busy", 16'(busy), 16'(e_busy));
        chk("data_valid", 16'(data_valid), 16'(e_dv));
        chk("data", data, exp_data);
        if (data_valid) dv_cnt++;
        if (bus.convst) conv_hi++;
        if (bus.sclk && !prev_sclk) begin
            chk("sclk_rise_cs_low", 16'(bus.cs_n), 16'd0);
            rise_cnt++;
        end
        if (bus.cs_n && !prev_cs_n) begin
            if (rst_n) chk("rises_per_frame", 16'(rise_cnt), 16'd16);
            rise_cnt = 0;
            seen_fr  = 1'b1;
        end
        if (!bus.cs_n && prev_cs_n && seen_fr)
            chk("cs_n_gap_ge2", 16'(hi_run >= 2), 16'd1);
        hi_run    = bus.cs_n ? hi_run + 1 : 0;
        prev_sclk = bus.sclk;
        prev_cs_n = bus.cs_n;
    end

    task automatic pulse_start;
        @(negedge clk_in);
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
    endtask

    task automatic wait_dv(output int lat);
        lat = 0;
        do begin
            @(negedge clk_in);
            lat++;
        end while (!data_valid && lat < 300);
        chk("dv_seen", 16'(data_valid), 16'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat;
        int base;
        int n;

        rst_n = 1'b0;
        repeat (3) @(negedge clk_in);
        chk("rst_data", data, 16'h0000);
        chk("rst_cs_n", 16'(bus.cs_n), 16'd1);
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_convst", 16'(bus.convst), 16'd0);
        rst_n = 1'b1;

        next_word = 16'hA5C3;
        base      = conv_hi;
        pulse_start();
        wait_dv(lat);
        chk("basic_latency", 16'(lat), 16'd75);
        chk("basic_data", data, 16'hA5C3);
        chk("model_pin_data", exp_data, 16'hA5C3);
        chk("model_pin_dv", 16'(e_dv), 16'd1);
        #1;
        chk("basic_convst_cycles", 16'(conv_hi - base), 16'd8);
        repeat (3) @(negedge clk_in);

        next_word = 16'hFFFF;
        pulse_start();
        wait_dv(lat);
        chk("ffff_data", data, 16'hFFFF);
        repeat (20) @(negedge clk_in);
        chk("ffff_hold", data, 16'hFFFF);
        next_word = 16'h0000;
        pulse_start();
        wait_dv(lat);
        chk("zero_data", data, 16'h0000);
        repeat (5) @(negedge clk_in);

        next_word = 16'h3C5A;
        #1;
        base = dv_cnt;
        pulse_start();
        repeat (3) @(negedge clk_in);
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        repeat (20) @(negedge clk_in);
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        repeat (100) @(negedge clk_in);
        #1;
        chk("busy_start_one_dv", 16'(dv_cnt - base), 16'd1);
        chk("busy_start_data", data, 16'h3C5A);

        base  = dv_cnt;
        n     = 0;
        start = 1'b1;
        while ((dv_cnt - base) < 3 && n < 400) begin
            @(negedge clk_in);
            next_word = 16'($urandom);
            #1;
            n++;
        end
        start = 1'b0;
        chk("held_three_dv", 16'(dv_cnt - base), 16'd3);
        repeat (90) @(negedge clk_in);
        #1;
        chk("held_no_extra", 16'(dv_cnt - base), 16'd3);

        next_word = 16'h1234;
        base      = dv_cnt;
        pulse_start();
        n = 0;
        while (rise_cnt < 7 && n < 200) begin
            @(negedge clk_in);
            #1;
            n++;
        end
        chk("mid_rises", 16'(rise_cnt), 16'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_convst", 16'(bus.convst), 16'd0);
        chk("mid_rst_cs_n", 16'(bus.cs_n), 16'd1);
        chk("mid_rst_sclk", 16'(bus.sclk), 16'd0);
        chk("mid_rst_data", data, 16'h0000);
        chk("mid_rst_dv", 16'(data_valid), 16'd0);
        chk("mid_rst_busy", 16'(busy), 16'd0);
        repeat (3) @(negedge clk_in);
        next_word = 16'hBEEF;
        rst_n     = 1'b1;
        start     = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        wait_dv(lat);
        chk("post_rst_latency", 16'(lat), 16'd75);
        chk("post_rst_data", data, 16'hBEEF);
        #1;
        chk("post_rst_one_dv", 16'(dv_cnt - base), 16'd1);

        for (int i = 0; i < 2500; i++) begin
            @(negedge clk_in);
            start     = ($urandom_range(0, 7) == 0);
            rst_n     = ($urandom_range(0, 599) != 0);
            next_word = 16'($urandom);
        end
        @(negedge clk_in);
        start = 1'b0;
        rst_n = 1'b1;
        repeat (100) @(negedge clk_in);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
